// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: register indices, control bit
// positions, display mode codes, port select encodings and FSM states.
package vdp_pkg;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R4 = 3'd4;

  localparam int R0_M3 = 1;
  localparam int R1_BL = 6;
  localparam int R1_IE = 5;
  localparam int R1_M1 = 4;
  localparam int R1_M2 = 3;

  localparam logic [1:0] MODE_TEXT1 = 2'd0;
  localparam logic [1:0] MODE_GFX1  = 2'd1;
  localparam logic [1:0] MODE_GFX2  = 2'd2;
  localparam logic [1:0] MODE_MULTI = 2'd3;

  typedef enum logic {
    CTRL_FIRST,
    CTRL_SECOND
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_CAPTURE
  } pf_state_t;

  // M1 has priority over M3, which has priority over M2.
  function automatic logic [1:0] vdp_mode(input logic [7:0] r0, input logic [7:0] r1);
    if (r1[R1_M1])      return MODE_TEXT1;
    else if (r0[R0_M3]) return MODE_GFX2;
    else if (r1[R1_M2]) return MODE_MULTI;
    else                return MODE_GFX1;
  endfunction

endpackage

// File: rtl/vdp_int_sync.sv
// Brings the video block's active-low frame interrupt into the CPU clock
// domain and produces a single-cycle pulse on each falling edge.
module vdp_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_reset,
  input  logic n_int_in,
  output logic frame_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // synchroniser chain plus one delayed copy for edge detection; idles high
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= n_int_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // falling edge of the synchronised interrupt
  assign frame_pulse = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/vdp_port.sv
// CPU-side port of the video block: data/control port decode, VDP registers
// R0-R7, VRAM access pointer with read-ahead buffer, status F flag and the
// CPU interrupt.
//
// state        | meaning
// CTRL_FIRST   | next control write is the first byte of a pair
// CTRL_SECOND  | first byte held in tmp; next control write completes the pair
// PF_IDLE      | no prefetch; strobes are accepted
// PF_FETCH     | vram_addr presents ptr to the VRAM
// PF_CAPTURE   | VRAM data lands in read_buf, ptr advances
module vdp_port
  import vdp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        port_sel,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        busy,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [1:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] font_addr,
  output logic        video_on,
  input  logic        n_int_in,
  output logic        n_int
);

  ctrl_state_t ctrl_state, ctrl_next;
  pf_state_t   pf_state, pf_next;

  logic [7:0]  regs [0:7];
  logic [7:0]  tmp;
  logic [13:0] ptr;
  logic [13:0] wr_addr;
  logic [7:0]  read_buf;
  logic        f_flag;
  logic        frame_pulse;

  logic accept, ctrl_wr, data_wr, data_rd, stat_rd;
  logic tmp_load, reg_load, ptr_load, setup_rd, capture;
  logic unused_bits;

  vdp_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
    .clk         (clk),
    .n_reset     (n_reset),
    .n_int_in    (n_int_in),
    .frame_pulse (frame_pulse)
  );

  // strobe decode; any strobe is dropped while a prefetch owns the pointer
  always_comb begin
    accept  = (pf_state == PF_IDLE);
    ctrl_wr = cpu_wr & (port_sel == PORT_CTRL) & accept;
    data_wr = cpu_wr & (port_sel == PORT_DATA) & accept;
    data_rd = cpu_rd & ~cpu_wr & (port_sel == PORT_DATA) & accept;
    stat_rd = cpu_rd & ~cpu_wr & (port_sel == PORT_CTRL) & accept;
  end

  // control byte latch: next state and the action the second byte triggers
  always_comb begin
    ctrl_next = ctrl_state;
    tmp_load  = 1'b0;
    reg_load  = 1'b0;
    ptr_load  = 1'b0;
    setup_rd  = 1'b0;
    if (ctrl_wr) begin
      if (ctrl_state == CTRL_FIRST) begin
        tmp_load  = 1'b1;
        ctrl_next = CTRL_SECOND;
      end else begin
        ctrl_next = CTRL_FIRST;
        if (cpu_din[7]) begin
          reg_load = 1'b1;
        end else begin
          ptr_load = 1'b1;
          setup_rd = ~cpu_din[6];
        end
      end
    end else if (data_wr | data_rd | stat_rd) begin
      ctrl_next = CTRL_FIRST;
    end
  end

  // prefetch sequencer: one address cycle, one capture cycle
  always_comb begin
    pf_next = pf_state;
    capture = 1'b0;
    case (pf_state)
      PF_IDLE:    if (setup_rd | data_rd) pf_next = PF_FETCH;
      PF_FETCH:   pf_next = PF_CAPTURE;
      PF_CAPTURE: begin
        capture = 1'b1;
        pf_next = PF_IDLE;
      end
      default:    pf_next = PF_IDLE;
    endcase
  end

  // state registers for both FSMs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ctrl_state <= CTRL_FIRST;
      pf_state   <= PF_IDLE;
    end else begin
      ctrl_state <= ctrl_next;
      pf_state   <= pf_next;
    end
  end

  // register file and the first control byte
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      tmp <= '0;
    end else begin
      if (tmp_load) tmp <= cpu_din;
      if (reg_load) regs[cpu_din[2:0]] <= tmp;
    end
  end

  // access pointer and read-ahead buffer; a data write also refreshes the buffer
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ptr      <= '0;
      read_buf <= '0;
    end else begin
      if (ptr_load) begin
        ptr <= {cpu_din[5:0], tmp};
      end else if (data_wr | capture) begin
        ptr <= ptr + 14'd1;
      end
      if (data_wr) begin
        read_buf <= cpu_din;
      end else if (capture) begin
        read_buf <= vram_rdata;
      end
    end
  end

  // VRAM write pulse: address is frozen because ptr has already advanced
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      wr_addr    <= '0;
    end else begin
      vram_we <= data_wr;
      if (data_wr) begin
        vram_wdata <= cpu_din;
        wr_addr    <= ptr;
      end
    end
  end

  // status F flag: a frame edge in the same cycle as a status read wins
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      f_flag <= 1'b0;
    end else if (frame_pulse) begin
      f_flag <= 1'b1;
    end else if (stat_rd) begin
      f_flag <= 1'b0;
    end
  end

  assign busy            = (pf_state != PF_IDLE);
  assign vram_addr       = vram_we ? wr_addr : ptr;
  assign cpu_dout        = (port_sel == PORT_CTRL) ? {f_flag, 7'b0} : read_buf;
  assign n_int           = ~(f_flag & regs[REG_R1][R1_IE]);
  assign video_on        = regs[REG_R1][R1_BL];
  assign mode            = vdp_mode(regs[REG_R0], regs[REG_R1]);
  assign name_table_addr = {regs[REG_R2][3:0], 10'b0};
  assign font_addr       = {regs[REG_R4][2:0], 11'b0};

  // registers and bits held for software but not consumed by this block
  assign unused_bits = ^{regs[0], regs[1], regs[2], regs[3],
                         regs[4], regs[5], regs[6], regs[7]};

endmodule

// File: tb/tb_vdp_port.sv
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        port_sel, cpu_wr, cpu_rd;
  logic [7:0]  cpu_din, cpu_dout;
  logic        busy;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_we;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, font_addr;
  logic        video_on, n_int_in, n_int;

  int checks = 0;
  int errors = 0;

  vdp_port #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .port_sel        (port_sel),
    .cpu_wr          (cpu_wr),
    .cpu_rd          (cpu_rd),
    .cpu_din         (cpu_din),
    .cpu_dout        (cpu_dout),
    .busy            (busy),
    .vram_addr       (vram_addr),
    .vram_wdata      (vram_wdata),
    .vram_we         (vram_we),
    .vram_rdata      (vram_rdata),
    .mode            (mode),
    .name_table_addr (name_table_addr),
    .font_addr       (font_addr),
    .video_on        (video_on),
    .n_int_in        (n_int_in),
    .n_int           (n_int)
  );

  always #5 clk = ~clk;

  // VRAM seen by the DUT: synchronous read, data valid the cycle after the address
  logic [7:0] vram    [0:16383];
  logic [7:0] ref_mem [0:16383];
  always @(posedge clk) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    vram_rdata <= vram[vram_addr];
  end

  // reference model of the programmer-visible state
  logic [7:0]  m_regs [0:7];
  logic [13:0] m_ptr;
  logic [7:0]  m_buf, m_tmp;
  logic        m_second, m_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_mode();
    if (m_regs[1][4]) return 2'd0;
    if (m_regs[0][1]) return 2'd2;
    if (m_regs[1][3]) return 2'd3;
    return 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = '0; m_buf = '0; m_tmp = '0; m_second = 1'b0; m_f = 1'b0;
  endtask

  task automatic model_prefetch();
    m_buf = ref_mem[m_ptr];
    m_ptr = m_ptr + 14'd1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_mode"}, mode, m_mode());
    chk({tag, "_name"}, name_table_addr, {m_regs[2][3:0], 10'b0});
    chk({tag, "_font"}, font_addr, {m_regs[4][2:0], 11'b0});
    chk({tag, "_video_on"}, video_on, m_regs[1][6]);
    chk({tag, "_n_int"}, n_int, !(m_f && m_regs[1][5]));
    chk({tag, "_ptr"}, vram_addr, m_ptr);
    chk({tag, "_we_idle"}, vram_we, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_dout"}, cpu_dout, port_sel ? {m_f, 7'b0} : m_buf);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs[i], m_regs[i]);
  endtask

  task automatic do_wr(input logic sel, input logic [7:0] d, output int busy_cyc);
    logic        exp_pf = 1'b0;
    logic        exp_w  = 1'b0;
    logic [13:0] exp_a  = '0;
    int          nwe    = 0;
    busy_cyc = 0;
    @(negedge clk);
    chk("strobe_spacing", busy, 1'b0);
    port_sel = sel; cpu_din = d; cpu_wr = 1'b1;
    if (sel == 1'b0) begin
      exp_w = 1'b1; exp_a = m_ptr;
      ref_mem[m_ptr] = d; m_buf = d; m_ptr = m_ptr + 14'd1; m_second = 1'b0;
    end else if (!m_second) begin
      m_tmp = d; m_second = 1'b1;
    end else begin
      m_second = 1'b0;
      if (d[7]) m_regs[d[2:0]] = m_tmp;
      else begin
        m_ptr = {d[5:0], m_tmp};
        if (!d[6]) begin exp_pf = 1'b1; model_prefetch(); end
      end
    end
    @(negedge clk);
    cpu_wr = 1'b0;
    if (exp_w) begin
      chk("wr_we", vram_we, 1'b1);
      chk("wr_addr", vram_addr, exp_a);
      chk("wr_data", vram_wdata, d);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (vram_we === 1'b1) nwe++;
    end
    chk("wr_busy_cycles", busy_cyc, exp_pf ? 2 : 0);
    chk("wr_we_cycles", nwe, exp_w ? 1 : 0);
  endtask

  task automatic do_rd(input logic sel, output logic [7:0] d);
    logic [7:0] exp_d;
    int         nbusy = 0;
    @(negedge clk);
    chk("strobe_spacing", busy, 1'b0);
    port_sel = sel; cpu_rd = 1'b1;
    #1;
    d = cpu_dout;
    m_second = 1'b0;
    if (sel) begin exp_d = {m_f, 7'b0}; m_f = 1'b0; end
    else     begin exp_d = m_buf; model_prefetch(); end
    chk(sel ? "status_rd" : "data_rd", d, exp_d);
    @(negedge clk);
    cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    chk("rd_busy_cycles", nbusy, sel ? 0 : 2);
  endtask

  task automatic frame_in();
    @(negedge clk);
    n_int_in = 1'b0;
    repeat (4) @(negedge clk);
    n_int_in = 1'b1;
    repeat (5) @(negedge clk);
    m_f = 1'b1;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    port_sel = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00; n_int_in = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int         bc, nwe;
    logic [7:0] d, r;
    for (int i = 0; i < 16384; i++) begin
      vram[i] = 8'($urandom);
      ref_mem[i] = vram[i];
    end
    apply_reset();
    check_state("reset");
    chk("reset_mode", mode, 2'd1);

    // 1: register writes
    do_wr(1, 8'h40, bc); do_wr(1, 8'h80, bc);
    do_wr(1, 8'h70, bc); do_wr(1, 8'h81, bc);
    chk("t1_video_on", video_on, 1'b1);
    chk("t1_mode", mode, 2'd0);
    chk("t1_r1", dut.regs[1], 8'h70);
    do_wr(1, 8'h05, bc); do_wr(1, 8'h82, bc);
    chk("t1_name", name_table_addr, 14'h1400);
    check_state("t1");

    // 2: data writes and pointer wrap
    do_wr(1, 8'h00, bc); do_wr(1, 8'h7F, bc);
    chk("t2_ptr0", vram_addr, 14'h3F00);
    do_wr(0, 8'hAA, bc); do_wr(0, 8'h55, bc);
    chk("t2_ptr", vram_addr, 14'h3F02);
    do_wr(1, 8'hFF, bc); do_wr(1, 8'h7F, bc);
    do_wr(0, 8'h3C, bc);
    chk("t2_wrap", vram_addr, 14'h0000);
    check_state("t2");

    // 3: read setup and read-ahead
    vram[14'h0100] = 8'h11; ref_mem[14'h0100] = 8'h11;
    vram[14'h0101] = 8'h22; ref_mem[14'h0101] = 8'h22;
    do_wr(1, 8'h00, bc); do_wr(1, 8'h01, bc);
    chk("t3_busy", bc, 2);
    do_rd(0, d); chk("t3_rd0", d, 8'h11);
    do_rd(0, d); chk("t3_rd1", d, 8'h22);
    chk("t3_ptr", vram_addr, 14'h0103);
    check_state("t3");

    // 4: frame interrupt and status read
    @(negedge clk);
    n_int_in = 1'b0;
    for (int i = 0; i < 10 && n_int !== 1'b0; i++) @(negedge clk);
    chk("t4_n_int_low", n_int, 1'b0);
    n_int_in = 1'b1;
    m_f = 1'b1;
    repeat (4) @(negedge clk);
    do_rd(1, d); chk("t4_status", d, 8'h80);
    chk("t4_n_int_high", n_int, 1'b1);
    do_rd(1, d); chk("t4_status2", d, 8'h00);
    check_state("t4");

    // 5: data access resets the control byte latch
    do_wr(1, 8'h12, bc);
    do_rd(0, d);
    do_wr(1, 8'h34, bc); do_wr(1, 8'h87, bc);
    chk("t5_r7", dut.regs[7], 8'h34);
    check_state("t5");

    // 6a: reset in the middle of a prefetch
    do_wr(1, 8'h00, bc);
    @(negedge clk);
    port_sel = 1'b1; cpu_din = 8'h00; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
    chk("t6_busy_before", busy, 1'b1);
    n_reset = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_addr_rst", vram_addr, 14'h0000);
    chk("t6_mode_rst", mode, 2'd1);
    chk("t6_video_rst", video_on, 1'b0);
    chk("t6_nint_rst", n_int, 1'b1);
    chk("t6_status_rst", cpu_dout, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check_state("t6a");

    // 6b: reset while the write pulse is out
    do_wr(1, 8'h34, bc); do_wr(1, 8'h52, bc);
    @(negedge clk);
    port_sel = 1'b0; cpu_din = 8'h99; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
    chk("t6_we_before", vram_we, 1'b1);
    n_reset = 1'b0;
    #1;
    chk("t6_we_rst", vram_we, 1'b0);
    chk("t6_addr_rst2", vram_addr, 14'h0000);
    chk("t6_wdata_rst", vram_wdata, 8'h00);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    nwe = 0;
    repeat (5) begin
      @(negedge clk);
      if (vram_we !== 1'b0) nwe++;
    end
    chk("t6_no_we_after", nwe, 0);
    check_state("t6b");

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          r = 8'($urandom);
          do_wr(1, r, bc);
          do_wr(1, 8'h80 | (8'($urandom) & 8'h7F), bc);
        end
        3: begin
          do_wr(1, 8'($urandom), bc);
          do_wr(1, 8'($urandom) & 8'h7F, bc);
        end
        4, 5: do_wr(0, 8'($urandom), bc);
        6, 7: do_rd(0, d);
        8: do_rd(1, d);
        default: begin
          if ($urandom_range(0, 1) == 0) do_wr(1, 8'($urandom), bc);
          else frame_in();
        end
      endcase
      check_state("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
